// File: rtl/network_output_serialiser.sv
// Frame FIFO + requantising channel serialiser behind the dilated conv network.
// Define NETWORK_OUT_SAT_EN to clamp requantised samples instead of wrapping them.
module network_output_serialiser #(
  parameter int W     = 16,
  parameter int OUT_W = 10,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*W-1:0]           in_data,
  input  logic                     in_v,
  output logic [OUT_W-1:0]         m_data,
  output logic [1:0]               m_chan,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = W - SHIFT;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  // Handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
  // while m_valid && !m_ready the presented beat is held unchanged.
  state_t            state_q, state_d;
  logic [4*W-1:0]    mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q, level_d;
  logic [1:0]        chan_q;
  logic              ovf_q;
  logic [7:0]        drop_cnt_q;
  logic              beat, pop, push, drop;
  logic [4*W-1:0]    head;
  logic [W-1:0]      x;
  logic signed [W-1:0] shifted;
  logic [OUT_W-1:0]  q;
  logic              unused_hi;

  assign m_valid = (state_q == STREAM);
  assign beat    = m_valid && m_ready;
  assign pop     = beat && (chan_q == 2'd3);
  // A full FIFO still accepts when the head frame leaves on the same edge.
  assign push    = in_v && ((level_q < LW'(DEPTH)) || pop);
  assign drop    = in_v && !push;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next state looks at the post-edge level so a frame streams one cycle after in_v.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_d != '0) state_d = STREAM;
      STREAM:  if (level_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      chan_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (beat) chan_q <= chan_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (ovf_clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign head    = mem[rd_ptr];
  assign x       = head[chan_q*W +: W];
  assign shifted = $signed(x) >>> SHIFT;
  assign unused_hi = ^shifted;

  generate
    if (SW <= OUT_W) begin : g_ext
      assign q = OUT_W'(shifted);
    end else begin : g_red
`ifdef NETWORK_OUT_SAT_EN
      localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        q = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX)      q = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN) q = SAT_MIN[OUT_W-1:0];
      end
`else
      assign q = shifted[OUT_W-1:0];
`endif
    end
  endgenerate

  assign m_data   = m_valid ? q : '0;
  assign m_chan   = chan_q;
  assign m_last   = m_valid && (chan_q == 2'd3);
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule
